// File: rtl/splitting_4kb_bresp_merger.sv
// Write-response merger for the 4KB burst splitter.
// A small in-order FIFO records whether each accepted AW burst was split.
// Split bursts produce two slave B responses. They are folded into one master B response.
// Non-split responses pass straight through.
//
// Handshake rule on both B channels: a transfer happens on a rising ACLK edge when
// VALID and READY are both high. Once this block raises m_BVALID_o, it holds
// m_BVALID_o, m_BID_o and m_BRESP_o unchanged until m_BREADY_i is seen high.
module splitting_4kb_bresp_merger #(
   parameter int ID_WIDTH    = 5,
   parameter int OUTST_DEPTH = 4
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic                split_valid_i,
   input  logic                split_flag_i,
   output logic                split_ready_o,
   input  logic [ID_WIDTH-1:0] s_BID_i,
   input  logic [1:0]          s_BRESP_i,
   input  logic                s_BVALID_i,
   output logic                s_BREADY_o,
   output logic [ID_WIDTH-1:0] m_BID_o,
   output logic [1:0]          m_BRESP_o,
   output logic                m_BVALID_o,
   input  logic                m_BREADY_i,
   output logic [1:0]          state_dbg_o
);

   localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT2 = 2'd1,
      ST_OUT   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [OUTST_DEPTH-1:0] flag_mem_q, flag_mem_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [ID_WIDTH-1:0]    acc_id_q, acc_id_d;
   logic [1:0]             acc_resp_q, acc_resp_d;
   logic [ID_WIDTH-1:0]    m_bid_q, m_bid_d;
   logic [1:0]             m_bresp_q, m_bresp_d;
   logic                   m_bvalid_q, m_bvalid_d;

   logic full, empty, head_flag, push, pop, s_bready, s_hs;

   // Error codes dominate by severity (DECERR > SLVERR).
   // EXOKAY survives only if both halves were exclusive-okay.
   function automatic logic [1:0] merge_resp(input logic [1:0] a, input logic [1:0] b);
      if (a[1] || b[1]) begin
         return (a > b) ? a : b;
      end else if (a == 2'b01 && b == 2'b01) begin
         return 2'b01;
      end else begin
         return 2'b00;
      end
   endfunction

   // Fullness is taken from the registered count only, so a pop never frees a slot the same cycle.
   always_comb begin
      full      = (count_q == CNT_W'(OUTST_DEPTH));
      empty     = (count_q == '0);
      head_flag = flag_mem_q[rd_ptr_q];
      push      = split_valid_i && !full;
   end

   // Next-state logic for the merge FSM, the output registers and the flag FIFO.
   always_comb begin
      state_d    = state_q;
      acc_id_d   = acc_id_q;
      acc_resp_d = acc_resp_q;
      m_bid_d    = m_bid_q;
      m_bresp_d  = m_bresp_q;
      m_bvalid_d = m_bvalid_q;
      pop        = 1'b0;
      s_bready   = 1'b0;

      case (state_q)
         ST_IDLE:  s_bready = !empty;
         ST_WAIT2: s_bready = 1'b1;
         default:  s_bready = 1'b0;
      endcase
      s_hs = s_BVALID_i && s_bready;

      case (state_q)
         ST_IDLE: begin
            if (s_hs) begin
               if (!head_flag) begin
                  m_bid_d    = s_BID_i;
                  m_bresp_d  = s_BRESP_i;
                  m_bvalid_d = 1'b1;
                  pop        = 1'b1;
                  state_d    = ST_OUT;
               end else begin
                  // First half of a split pair: keep it and wait for the second half.
                  acc_id_d   = s_BID_i;
                  acc_resp_d = s_BRESP_i;
                  state_d    = ST_WAIT2;
               end
            end
         end
         ST_WAIT2: begin
            if (s_hs) begin
               // The BID of the second half is not checked; the first-half BID is returned.
               m_bid_d    = acc_id_q;
               m_bresp_d  = merge_resp(acc_resp_q, s_BRESP_i);
               m_bvalid_d = 1'b1;
               pop        = 1'b1;
               state_d    = ST_OUT;
            end
         end
         ST_OUT: begin
            if (m_BREADY_i) begin
               m_bvalid_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            m_bvalid_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase

      flag_mem_d = flag_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (push) begin
         flag_mem_d[wr_ptr_q] = split_flag_i;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
   end

   // State registers; reset drops all tracked flags and any held response.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q    <= ST_IDLE;
         flag_mem_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         acc_id_q   <= '0;
         acc_resp_q <= '0;
         m_bid_q    <= '0;
         m_bresp_q  <= '0;
         m_bvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         flag_mem_q <= flag_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         acc_id_q   <= acc_id_d;
         acc_resp_q <= acc_resp_d;
         m_bid_q    <= m_bid_d;
         m_bresp_q  <= m_bresp_d;
         m_bvalid_q <= m_bvalid_d;
      end
   end

   // Drive the output ports from the registers and the decoded ready signals.
   always_comb begin
      split_ready_o = !full;
      s_BREADY_o    = s_bready;
      m_BID_o       = m_bid_q;
      m_BRESP_o     = m_bresp_q;
      m_BVALID_o    = m_bvalid_q;
      state_dbg_o   = state_q;
   end

endmodule
